// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous dmem, with tagged read-data return.
// Define DMEM_ARB_RR_EN to swap fixed priority plus starvation guard for round-robin.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              p0_req,
  input  logic              p0_wren,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_q,

  input  logic              p1_req,
  input  logic              p1_wren,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_q,

  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  logic both_req;
  logic pick_p1;
  logic accept;

  assign both_req = p0_req & p1_req;

`ifdef DMEM_ARB_RR_EN
  logic last_winner_q, last_winner_d;

  always_comb begin
    pick_p1 = both_req ? ~last_winner_q : p1_req;
  end

  always_comb begin
    last_winner_d = last_winner_q;
    if (accept) begin
      last_winner_d = p1_gnt;
    end
  end

  // Resets to port 1 so that port 0 wins the first conflict.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_winner_q <= 1'b1;
    end else begin
      last_winner_q <= last_winner_d;
    end
  end
`else
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    pick_p1 = both_req ? (starve_cnt_q == StarveMax) : p1_req;
  end

  always_comb begin
    starve_cnt_d = 4'd0;
    if (p1_req && !p1_gnt) begin
      starve_cnt_d = (starve_cnt_q == StarveMax) ? starve_cnt_q : starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  always_comb begin
    p0_gnt = reset & p0_req & ~pick_p1;
    p1_gnt = reset & p1_req & pick_p1;
    accept = p0_gnt | p1_gnt;
  end

  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_wren_q, mem_wren_d;
  logic              rd1_vld_q, rd1_vld_d;
  logic              rd1_port_q, rd1_port_d;
  logic              rd2_vld_q, rd2_vld_d;
  logic              rd2_port_q, rd2_port_d;
  logic              p0_rvalid_q, p0_rvalid_d;
  logic              p1_rvalid_q, p1_rvalid_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

  always_comb begin
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_wren_d    = 1'b0;
    if (p1_gnt) begin
      mem_address_d = p1_addr;
      mem_data_d    = p1_data;
      mem_wren_d    = p1_wren;
    end else if (p0_gnt) begin
      mem_address_d = p0_addr;
      mem_data_d    = p0_data;
      mem_wren_d    = p0_wren;
    end
  end

  // Tag travels two stages so it lines up with mem_q for the command it belongs to.
  always_comb begin
    rd1_vld_d   = accept & ~mem_wren_d;
    rd1_port_d  = p1_gnt;
    rd2_vld_d   = rd1_vld_q;
    rd2_port_d  = rd1_port_q;
    p0_rvalid_d = rd2_vld_q & ~rd2_port_q;
    p1_rvalid_d = rd2_vld_q & rd2_port_q;
    p0_rdata_d  = p0_rvalid_d ? mem_q : p0_rdata_q;
    p1_rdata_d  = p1_rvalid_d ? mem_q : p1_rdata_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      rd1_vld_q     <= 1'b0;
      rd1_port_q    <= 1'b0;
      rd2_vld_q     <= 1'b0;
      rd2_port_q    <= 1'b0;
      p0_rvalid_q   <= 1'b0;
      p1_rvalid_q   <= 1'b0;
      p0_rdata_q    <= '0;
      p1_rdata_q    <= '0;
    end else begin
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
      rd1_vld_q     <= rd1_vld_d;
      rd1_port_q    <= rd1_port_d;
      rd2_vld_q     <= rd2_vld_d;
      rd2_port_q    <= rd2_port_d;
      p0_rvalid_q   <= p0_rvalid_d;
      p1_rvalid_q   <= p1_rvalid_d;
      p0_rdata_q    <= p0_rdata_d;
      p1_rdata_q    <= p1_rdata_d;
    end
  end

  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_wren    = mem_wren_q;
  assign p0_rvalid   = p0_rvalid_q;
  assign p1_rvalid   = p1_rvalid_q;
  assign p0_q        = p0_rdata_q;
  assign p1_q        = p1_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: a request-level reference model predicts grants and
// read returns; a separate monitor pops expected returns whenever the DUT presents rvalid.
module tb_dmem_port_arbiter;
  localparam int unsigned ADDR_W       = 12;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned STARVE_LIMIT = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset;
  logic              p0_req, p0_wren, p0_gnt, p0_rvalid;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_data, p0_q;
  logic              p1_req, p1_wren, p1_gnt, p1_rvalid;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_data, p1_q;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data, mem_q;
  logic              mem_wren;

  dmem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .p0_req     (p0_req),
    .p0_wren    (p0_wren),
    .p0_addr    (p0_addr),
    .p0_data    (p0_data),
    .p0_gnt     (p0_gnt),
    .p0_rvalid  (p0_rvalid),
    .p0_q       (p0_q),
    .p1_req     (p1_req),
    .p1_wren    (p1_wren),
    .p1_addr    (p1_addr),
    .p1_data    (p1_data),
    .p1_gnt     (p1_gnt),
    .p1_rvalid  (p1_rvalid),
    .p1_q       (p1_q),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .mem_q      (mem_q)
  );

  // Single-port synchronous RAM seen by the DUT (read-old-data on a same-edge write).
  logic [DATA_W-1:0] sram [1 << ADDR_W];
  always @(posedge clock) begin
    if (mem_wren) sram[mem_address] <= mem_data;
    mem_q <= sram[mem_address];
  end

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
  endtask

  // Reference state, expressed at request level.
  typedef struct {
    bit                port;
    logic [DATA_W-1:0] data;
    int                cyc;
  } rd_t;

  rd_t               sb[$];
  logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
  int unsigned       denied_run = 0;
  bit                lw = 1'b1;
  bit                eg0, eg1, obs_g0, obs_g1;
  bit                mon_en = 1'b0;
  logic              exp_wren = 1'b0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] exp_data = '0;
  logic [DATA_W-1:0] exp_q0 = '0, exp_q1 = '0;

  // Monitor: registered outputs are sampled 1 time unit after the rising edge.
  rd_t               mon_e;
  bit                mon_port;
  logic [DATA_W-1:0] mon_dat;
  always @(posedge clock) begin
    #1;
    if (mon_en) begin
      if (p0_rvalid || p1_rvalid) begin
        check(!(p0_rvalid && p1_rvalid), "dual_rvalid", 64'({p0_rvalid, p1_rvalid}), 64'd0);
        check(sb.size() != 0, "unexpected_rvalid", 64'({p0_rvalid, p1_rvalid}), 64'd0);
        if (sb.size() != 0) begin
          mon_e    = sb.pop_front();
          mon_port = p1_rvalid;
          mon_dat  = p1_rvalid ? p1_q : p0_q;
          check(mon_port == mon_e.port && mon_dat == mon_e.data, "read_return",
                64'({mon_port, mon_dat}), 64'({mon_e.port, mon_e.data}));
          check(cyc == mon_e.cyc, "read_latency", 64'(cyc), 64'(mon_e.cyc));
          if (mon_e.port) exp_q1 = mon_e.data;
          else exp_q0 = mon_e.data;
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        check(p0_rvalid || p1_rvalid, "missing_rvalid", 64'(cyc), 64'(sb[0].cyc));
        void'(sb.pop_front());
      end
      check(p0_q == exp_q0 && p1_q == exp_q1, "q_hold", 64'({p0_q, p1_q}),
            64'({exp_q0, exp_q1}));
      check(mem_wren == exp_wren && mem_address == exp_addr && mem_data == exp_data, "mem_cmd",
            64'({mem_wren, mem_address, mem_data}), 64'({exp_wren, exp_addr, exp_data}));
    end
  end

  // One cycle: check grants at the falling edge, advance the model, then wait past the edge.
  task automatic tick();
    bit                pick1;
    bit                w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    @(negedge clock);
    if (!reset) begin
      eg0 = 1'b0;
      eg1 = 1'b0;
    end else if (p0_req && p1_req) begin
`ifdef DMEM_ARB_RR_EN
      pick1 = !lw;
`else
      pick1 = (denied_run == STARVE_LIMIT);
`endif
      eg0 = !pick1;
      eg1 = pick1;
    end else begin
      eg0 = p0_req;
      eg1 = p1_req;
    end
    obs_g0 = p0_gnt;
    obs_g1 = p1_gnt;
    check({p0_gnt, p1_gnt} == {eg0, eg1}, "grant", 64'({p0_gnt, p1_gnt}), 64'({eg0, eg1}));
    if (!reset) begin
      sb.delete();
      denied_run = 0;
      lw         = 1'b1;
      exp_wren   = 1'b0;
      exp_addr   = '0;
      exp_data   = '0;
      exp_q0     = '0;
      exp_q1     = '0;
    end else begin
      if (p1_req && !eg1) denied_run = (denied_run < STARVE_LIMIT) ? denied_run + 1 : denied_run;
      else denied_run = 0;
      if (eg0 || eg1) begin
        lw = eg1;
        w  = eg1 ? p1_wren : p0_wren;
        a  = eg1 ? p1_addr : p0_addr;
        d  = eg1 ? p1_data : p0_data;
        exp_wren = w;
        exp_addr = a;
        exp_data = d;
        if (w) ref_mem[a] = d;
        else sb.push_back('{port: eg1, data: ref_mem[a], cyc: cyc + 3});
      end else begin
        exp_wren = 1'b0;
      end
    end
    @(posedge clock);
    #2;
  endtask

  task automatic p0_do(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit got = 1'b0;
    p0_req  = 1'b1;
    p0_wren = w;
    p0_addr = a;
    p0_data = d;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = obs_g0;
    end
    check(got, "p0_grant_timeout", 64'(got), 64'd1);
    p0_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int n0;
  bit seen_p1;

  initial begin
    reset = 1'b0;
    p0_req = 1'b1; p0_wren = 1'b1; p0_addr = '0; p0_data = '0;
    p1_req = 1'b1; p1_wren = 1'b1; p1_addr = '0; p1_data = '0;
    @(posedge clock);
    #2;
    mon_en = 1'b1;

    // Reset held with both requests high.
    for (int i = 0; i < 3; i++) begin
      tick();
      check(!obs_g0 && !obs_g1, "gnt_in_reset", 64'({obs_g0, obs_g1}), 64'd0);
    end
    reset = 1'b1;
    tick();
    check(obs_g0 && !obs_g1, "first_gnt_after_reset", 64'({obs_g0, obs_g1}), 64'b10);
    p0_req = 1'b0;
    p1_req = 1'b0;
    idle(2);

    // Write then read back on port 0.
    p0_do(1'b1, 12'h010, 32'hDEADBEEF);
    p0_do(1'b0, 12'h010, '0);
    idle(3);
    check(p0_q == 32'hDEADBEEF, "single_read_q", 64'(p0_q), 64'hDEADBEEF);

    for (int i = 0; i < 16; i++) p0_do(1'b1, ADDR_W'(i), $urandom);
    idle(3);

    // Conflict from a fresh reset: port 1 holds, port 0 re-requests every cycle.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    p0_req = 1'b1; p0_wren = 1'b0; p0_addr = 12'h001;
    p1_req = 1'b1; p1_wren = 1'b0; p1_addr = 12'h002;
    n0 = 0;
    seen_p1 = 1'b0;
    for (int i = 0; i < 20 && !seen_p1; i++) begin
      tick();
      if (obs_g1) seen_p1 = 1'b1;
      else if (obs_g0) n0++;
    end
`ifdef DMEM_ARB_RR_EN
    check(seen_p1 && n0 == 1, "rr_first_alternation", 64'(n0), 64'd1);
`else
    check(seen_p1 && n0 == int'(STARVE_LIMIT), "starve_wins", 64'(n0), 64'(STARVE_LIMIT));
`endif
    p1_req = 1'b0;
    p1_req = 1'b1;
    idle(6);
    p0_req = 1'b0;
    p1_req = 1'b0;
    idle(3);

    // Alternating-port reads return in order on consecutive cycles.
    p0_do(1'b1, 12'h020, 32'h11);
    p0_do(1'b1, 12'h021, 32'h22);
    p0_do(1'b1, 12'h022, 32'h33);
    p0_req = 1'b1; p0_wren = 1'b0; p0_addr = 12'h020;
    tick();
    p0_req = 1'b0;
    p1_req = 1'b1; p1_wren = 1'b0; p1_addr = 12'h021;
    tick();
    p1_req = 1'b0;
    p0_req = 1'b1; p0_wren = 1'b0; p0_addr = 12'h022;
    tick();
    p0_req = 1'b0;
    idle(3);
    check(p0_q == 32'h33 && p1_q == 32'h22, "interleave_final_q", 64'({p0_q, p1_q}),
          64'({32'h33, 32'h22}));

    // Reset right after a port 1 read accept cancels its return.
    p1_req = 1'b1; p1_wren = 1'b0; p1_addr = 12'h020;
    tick();
    p1_req = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check(!p1_rvalid && p1_q == '0, "midflight_reset", 64'({p1_rvalid, p1_q}), 64'd0);
    end

    // Randomised traffic on a small address window, with occasional drops and resets.
    for (int i = 0; i < 500; i++) begin
      if (!p0_req || eg0) begin
        p0_req  = ($urandom_range(0, 2) != 0);
        p0_wren = $urandom_range(0, 1) == 1;
        p0_addr = ADDR_W'($urandom_range(0, 15));
        p0_data = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        p0_req = 1'b0;
      end
      if (!p1_req || eg1) begin
        p1_req  = ($urandom_range(0, 2) != 0);
        p1_wren = $urandom_range(0, 1) == 1;
        p1_addr = ADDR_W'($urandom_range(0, 15));
        p1_data = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        p1_req = 1'b0;
      end
      reset = ($urandom_range(0, 63) != 0);
      tick();
    end
    reset  = 1'b1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    idle(5);
    check(sb.size() == 0, "scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port synchronous dmem between two requesters: port 0 (processor load/store path) and port 1 (loader/debug DMA).
- Sits between the requesters and the dmem syncram.
- Accepts at most one request per cycle, drives registered memory commands, and routes read data back to the issuing port with a tagged pipeline.
- Default policy is fixed priority to port 0, with a starvation guard for port 1.

Parameters:
- ADDR_W, 12, dmem address width.
- DATA_W, 32, dmem data width.
- STARVE_LIMIT, 4, consecutive denied cycles after which port 1 wins a conflict (range 1..15).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets).
- p0_req  in  1  port 0 request valid; held until p0_gnt.
- p0_wren  in  1  port 0 write (1) / read (0).
- p0_addr  in  ADDR_W  port 0 address.
- p0_data  in  DATA_W  port 0 write data.
- p0_gnt  out  1  combinational; request accepted at this rising edge.
- p0_rvalid  out  1  one-cycle pulse, p0_q valid.
- p0_q  out  DATA_W  port 0 read data.
- p1_req, p1_wren, p1_addr, p1_data, p1_gnt, p1_rvalid, p1_q: same as port 0, for port 1.
- mem_address  out  ADDR_W  registered dmem address.
- mem_data  out  DATA_W  registered dmem write data.
- mem_wren  out  1  registered dmem write enable.
- mem_q  in  DATA_W  dmem read data; valid one clock after the command edge.

Behaviour:
- Reset values: mem_address=0, mem_data=0, mem_wren=0, p0_rvalid=p1_rvalid=0, p0_q=p1_q=0, starve counter=0, read-tag pipeline cleared.
- gnt outputs are forced 0 while reset==0.
- Grant, combinational in the current cycle:
  - Only p0_req: p0_gnt=1.
  - Only p1_req: p1_gnt=1.
  - Both: p0_gnt=1, unless starve_cnt==STARVE_LIMIT, in which case p1_gnt=1.
  - At most one gnt is high; neither is high with no req.
- Accept edge k (req&gnt): mem_address, mem_data and mem_wren are loaded from the winning port.
- Cycles with no accept: mem_wren loads 0; mem_address and mem_data hold their previous values.
- Read pipeline:
  - Stage 1 at edge k: record {valid=~wren, port}.
  - Stage 2 at edge k+1: stage 1 advances while the memory samples the command.
  - Edge k+2: mem_q is captured into the tagged port's pX_q and pX_rvalid=1 for one cycle; the other port's q holds.
  - Read latency is 2 edges after accept.
  - Back-to-back reads on alternating ports return in issue order, one per cycle.
- Writes: no rvalid. Data is committed at the dmem edge k+1.
- Read-after-write to the same address, issued on consecutive accepts, returns the new data (the memory is ordered).
- Starve counter, 4 bits, saturating at STARVE_LIMIT:
  - Increments each edge with p1_req=1 and p1_gnt=0.
  - Clears on a p1 accept or when p1_req=0.
- Requester dropping req before gnt: no accept, no side effect. The counter clears if it was port 1.
- Reset mid-operation: in-flight read tags are discarded, so no rvalid follows reset. mem_wren=0 on the reset edge, so a pending command is cancelled.
- Address/data widths pass through unchanged; there is no address translation.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined:
  - Round-robin replaces fixed priority.
  - A 1-bit last_winner register (reset 1, so port 0 wins the first conflict) records the port of every accept.
  - On conflict, grant goes to ~last_winner.
  - The starve counter and STARVE_LIMIT are unused and the counter is not synthesized.
- Undefined: fixed priority with the starvation guard as described in Behaviour.

Test Plan:
- Reset: hold reset=0 for 3 cycles with both reqs high -> both gnt=0, mem_wren=0, no rvalid; release -> p0 granted on the first cycle.
- Single read: p0 writes 0xDEADBEEF to addr 0x010, then reads addr 0x010 -> p0_gnt each cycle; p0_rvalid pulses 2 edges after the read accept with p0_q=0xDEADBEEF; p1_rvalid stays 0.
- Conflict with fixed priority: both reqs are held high continuously with reads (p0 addr 0x001, p1 addr 0x002), and port 0 presents a new request every cycle while port 1 holds the same request -> p0 wins 4 accepts, p1 wins the 5th (starve_cnt==4), then the counter clears.
- Interleaved returns: alternating accepts p0 read 0x020, p1 read 0x021, p0 read 0x022 (preloaded 0x11, 0x22, 0x33) -> rvalid sequence p0/0x11, p1/0x22, p0/0x33 on consecutive cycles.
- Reset mid-flight: accept a p1 read, then assert reset=0 on the next edge -> no p1_rvalid afterwards; p1_q=0.
- With DMEM_ARB_RR_EN: both reqs held continuously -> grants alternate p0, p1, p0, p1 starting with p0.
